// File: rtl/pulse_detect_multi.sv
// Multi-channel edge detector: per-channel synchronizer, glitch filter, mode-selected
// one-cycle event pulse, and saturating event counter with sticky overflow.
module pulse_detect_multi #(
  parameter int unsigned CH          = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       sig_in,
  input  logic [2*CH-1:0]     mode,
  input  logic                clr_cnt,
  output logic [CH-1:0]       filt_lvl,
  output logic [CH-1:0]       pulse_out,
  output logic [CH*CNT_W-1:0] evt_cnt,
  output logic [CH-1:0]       ovf
);

  localparam int unsigned FC_W = $clog2(FILT_LEN + 1);
  localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;

  logic [SYNC_STAGES-1:0][CH-1:0] sync_q, sync_d;
  logic [CH-1:0][FC_W-1:0]        fc_q, fc_d;
  logic [CH-1:0]                  filt_q, filt_d;
  logic [CH-1:0]                  lvl_dly_q, lvl_dly_d;
  logic [CH-1:0]                  pulse_q, pulse_d;
  logic [CH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [CH-1:0]                  ovf_q, ovf_d;

  logic [CH-1:0] sync_o;
  logic [CH-1:0] rise_c, fall_c;

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_c = filt_q & ~lvl_dly_q;
  assign fall_c = ~filt_q & lvl_dly_q;

  // Next-state: synchronizer shift, filter, edge qualification, counters.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], sig_in};
    fc_d      = fc_q;
    filt_d    = filt_q;
    lvl_dly_d = filt_q;
    pulse_d   = '0;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;

    for (int i = 0; i < int'(CH); i++) begin
      if (sync_o[i] == filt_q[i]) begin
        fc_d[i] = '0;
      end else if (fc_q[i] == FC_LAST) begin
        filt_d[i] = sync_o[i];
        fc_d[i]   = '0;
      end else begin
        fc_d[i] = fc_q[i] + FC_W'(1);
      end

      // Events come only from a filtered-level transition, so a stale level never pulses.
      pulse_d[i] = (rise_c[i] && ((mode[2*i +: 2] == MODE_RISE) || (mode[2*i +: 2] == MODE_BOTH)))
                || (fall_c[i] && ((mode[2*i +: 2] == MODE_FALL) || (mode[2*i +: 2] == MODE_BOTH)));

      // Clear wins over saturation, but a coincident event is still counted.
      if (clr_cnt) begin
        cnt_d[i] = pulse_d[i] ? CNT_W'(1) : '0;
        ovf_d[i] = 1'b0;
      end else if (pulse_d[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      fc_q      <= '0;
      filt_q    <= '0;
      lvl_dly_q <= '0;
      pulse_q   <= '0;
      cnt_q     <= '0;
      ovf_q     <= '0;
    end else begin
      sync_q    <= sync_d;
      fc_q      <= fc_d;
      filt_q    <= filt_d;
      lvl_dly_q <= lvl_dly_d;
      pulse_q   <= pulse_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  assign filt_lvl  = filt_q;
  assign pulse_out = pulse_q;
  assign evt_cnt   = cnt_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pulse_detect_multi.sv
// Directed bench for pulse_detect_multi: latency, glitch rejection, edge modes,
// saturation/clear, disable/re-enable and mid-operation reset.
module tb_pulse_detect_multi;

  logic        clk;
  logic        rst;
  logic [3:0]  sig_in;
  logic [7:0]  mode;
  logic        clr_cnt;
  logic [3:0]  filt_lvl;
  logic [3:0]  pulse_out;
  logic [31:0] evt_cnt;
  logic [3:0]  ovf;

  int n_checks;
  int n_errors;

  pulse_detect_multi #(
    .CH(4), .SYNC_STAGES(2), .FILT_LEN(3), .CNT_W(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (sig_in),
    .mode     (mode),
    .clr_cnt  (clr_cnt),
    .filt_lvl (filt_lvl),
    .pulse_out(pulse_out),
    .evt_cnt  (evt_cnt),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise sig_in[ch], drop it after hi edges (hi=0 keeps it high), observe for tot edges.
  task automatic pulse_in(input int ch, input int hi, input int tot,
                          output int np, output int first, output int last, output int nlvl);
    np = 0; first = -1; last = -1; nlvl = 0;
    sig_in[ch] = 1'b1;
    for (int i = 1; i <= tot; i++) begin
      tick();
      if (i == hi) sig_in[ch] = 1'b0;
      if (pulse_out[ch]) begin
        np++;
        if (first < 0) first = i;
        last = i;
      end
      if (filt_lvl[ch]) nlvl++;
    end
  endtask

  int np, first, last, nlvl, total;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    sig_in   = '0;
    mode     = '0;
    clr_cnt  = 1'b0;
    tick();
    tick();
    chk("rst_filt",  32'(filt_lvl),  32'h0);
    chk("rst_pulse", 32'(pulse_out), 32'h0);
    chk("rst_cnt",   evt_cnt,        32'h0);
    chk("rst_ovf",   32'(ovf),       32'h0);

    // Basic latency on ch0
    rst       = 1'b0;
    sig_in[0] = 1'b1;
    repeat (4) tick();
    chk("lat_filt_e4",  32'(filt_lvl),  32'h0);
    tick();
    chk("lat_filt_e5",  32'(filt_lvl),  32'h1);
    chk("lat_pulse_e5", 32'(pulse_out), 32'h0);
    tick();
    chk("lat_pulse_e6", 32'(pulse_out), 32'h1);
    chk("lat_cnt_e6",   evt_cnt,        32'h0000_0001);
    tick();
    chk("lat_pulse_e7", 32'(pulse_out), 32'h0);
    chk("lat_cnt_e7",   evt_cnt,        32'h0000_0001);

    // Glitch rejection on ch1
    pulse_in(1, 2, 12, np, first, last, nlvl);
    chk("glitch_np",   32'(np),   32'd0);
    chk("glitch_lvl",  32'(nlvl), 32'd0);
    chk("glitch_cnt",  32'(evt_cnt[15:8]), 32'd0);
    pulse_in(1, 3, 15, np, first, last, nlvl);
    chk("min_np",    32'(np),    32'd1);
    chk("min_first", 32'(first), 32'd6);
    chk("min_lvl",   32'(nlvl),  32'd3);
    chk("min_cnt",   32'(evt_cnt[15:8]), 32'd1);

    // Both-edge then fall-only on ch2
    mode = 8'b0010_0000;
    pulse_in(2, 10, 25, np, first, last, nlvl);
    chk("both_np",    32'(np),    32'd2);
    chk("both_first", 32'(first), 32'd6);
    chk("both_last",  32'(last),  32'd16);
    chk("both_cnt",   32'(evt_cnt[23:16]), 32'd2);
    mode = 8'b0001_0000;
    pulse_in(2, 10, 25, np, first, last, nlvl);
    chk("fall_np",    32'(np),    32'd1);
    chk("fall_first", 32'(first), 32'd16);
    chk("fall_cnt",   32'(evt_cnt[23:16]), 32'd3);

    // Saturation on ch3
    total = 0;
    for (int e = 0; e < 255; e++) begin
      pulse_in(3, 4, 10, np, first, last, nlvl);
      total += np;
    end
    chk("sat_events",  32'(total),          32'd255);
    chk("sat_cnt255",  32'(evt_cnt[31:24]), 32'd255);
    chk("sat_ovf255",  32'(ovf),            32'h0);
    pulse_in(3, 4, 10, np, first, last, nlvl);
    chk("sat_np256",   32'(np),             32'd1);
    chk("sat_cnt256",  32'(evt_cnt[31:24]), 32'd255);
    chk("sat_ovf256",  32'(ovf),            32'h8);
    pulse_in(3, 4, 10, np, first, last, nlvl);
    chk("sat_cnt257",  32'(evt_cnt[31:24]), 32'd255);
    chk("sat_ovf257",  32'(ovf),            32'h8);

    // Clear coincident with a ch3 event
    sig_in[3] = 1'b1;
    repeat (5) tick();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_pulse", 32'(pulse_out), 32'h8);
    chk("clr_cnt",   evt_cnt,        32'h0100_0000);
    chk("clr_ovf",   32'(ovf),       32'h0);
    sig_in[3] = 1'b0;
    repeat (10) tick();

    // Disable ch0, toggle 0->1, then re-enable without input change
    mode      = 8'b0001_0011;
    sig_in[0] = 1'b0;
    repeat (10) tick();
    pulse_in(0, 0, 12, np, first, last, nlvl);
    chk("dis_np",   32'(np),          32'd0);
    chk("dis_filt", 32'(filt_lvl[0]), 32'd1);
    chk("dis_cnt",  32'(evt_cnt[7:0]), 32'd0);
    mode = 8'b0001_0000;
    pulse_in(0, 0, 10, np, first, last, nlvl);
    chk("reen_np",  32'(np),           32'd0);
    chk("reen_cnt", 32'(evt_cnt[7:0]), 32'd0);

    // Reset two cycles after ch1 rises; ch0 is also high and re-detects
    sig_in[1] = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_filt",  32'(filt_lvl),  32'h0);
    chk("mid_rst_pulse", 32'(pulse_out), 32'h0);
    chk("mid_rst_cnt",   evt_cnt,        32'h0);
    chk("mid_rst_ovf",   32'(ovf),       32'h0);
    rst = 1'b0;
    pulse_in(1, 0, 12, np, first, last, nlvl);
    chk("mid_np",    32'(np),    32'd1);
    chk("mid_first", 32'(first), 32'd6);
    chk("mid_cnt",   evt_cnt,    32'h0000_0101);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
